cipher_shift_decryptor: RTL and testbench
=========================================

CIPHER_SHIFT_DECRYPTOR -- requirements
Module: cipher_shift_decryptor

Interface
REQ-001 Parameter D_WIDTH, default 8: character width in bits; SHALL be at least 8.
REQ-002 Parameter KEY_WIDTH, default 16: key width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth; SHALL be a power of two, at least 2.
REQ-004 Parameter END_TOKEN, default 8'hFA: end-of-message character; passed through, never decrypted.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port data_i, input, D_WIDTH bits: encrypted character.
REQ-008 Port valid_i, input, 1 bit: data_i is valid this cycle.
REQ-009 Port key, input, KEY_WIDTH bits: shift key, sampled on each accepted beat.
REQ-010 Port mode_i, input, 1 bit: 0 = modular byte shift; 1 = alphabetic shift. Sampled on each accepted beat.
REQ-011 Port ready_i, input, 1 bit: downstream can take data_o this cycle.
REQ-012 Port data_o, output, D_WIDTH bits: decrypted character, head of the buffer.
REQ-013 Port valid_o, output, 1 bit: data_o is valid.
REQ-014 Port last_o, output, 1 bit: data_o is END_TOKEN; qualified by valid_o.
REQ-015 Port busy, output, 1 bit: block cannot accept input this cycle.

Function
REQ-016 The block SHALL accept a beat when valid_i=1 and busy=0; when valid_i=1 and busy=1 the beat SHALL be dropped with no state change.
REQ-017 An accepted beat SHALL be decrypted into a single-entry stage register (stage_v, stage_d, stage_last) at the accepting edge.
REQ-018 Mode 0: stage_d SHALL be (data_i - key[D_WIDTH-1:0]) mod 2^D_WIDTH.
REQ-019 Mode 1, k = key mod 26:
- 'A'..'Z' SHALL map to 'A' + ((c - 'A' - k) mod 26).
- 'a'..'z' SHALL map to 'a' + ((c - 'a' - k) mod 26).
- All other values SHALL pass through unchanged.
REQ-020 If data_i == END_TOKEN, the beat SHALL pass through unchanged in either mode, with stage_last=1.
REQ-021 At each edge where stage_v=1 and the FIFO is not full, or a pop occurs in the same edge, the stage SHALL be written to the FIFO tail. stage_v SHALL then clear, unless a new beat is accepted in the same edge.
REQ-022 The FIFO SHALL be show-ahead:
- valid_o = (count != 0).
- data_o and last_o = head entry.
- data_o = 0 and last_o = 0 when empty.
REQ-023 A pop SHALL occur at an edge where valid_o=1 and ready_i=1. Simultaneous push and pop SHALL leave count unchanged.
REQ-024 busy SHALL equal ((count + stage_v) >= FIFO_DEPTH). It SHALL be derived only from registered state, with no combinational path from any input.
REQ-025 Latency: a beat accepted at edge N into an empty block SHALL appear on data_o with valid_o=1 after edge N+1.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 count SHALL range 0..FIFO_DEPTH, and the block SHALL never overflow or underflow under any input sequence.
REQ-028 Output order SHALL equal acceptance order.
REQ-029 valid_o and data_o SHALL remain stable while valid_o=1 and ready_i=0.

Reset
REQ-030 While rst_n=0, independent of clk:
- count, both pointers and stage_v SHALL be 0.
- data_o, valid_o, last_o and busy SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered and staged beats. The first edge after release SHALL accept a new beat normally.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Mode 0, key=16'h0003, data_i=8'h44 accepted at edge N -> data_o=8'h41, valid_o=1 after edge N+1.
REQ-034 Mode 0, key=16'h0002, data_i=8'h01 -> data_o=8'hFF (wrap-around).
REQ-035 Mode 1, key=29, inputs 'a'(8'h61), 'C'(8'h43), '7'(8'h37) -> outputs 8'h78, 8'h5A, 8'h37, in order.
REQ-036 ready_i=0, FIFO_DEPTH=4, five consecutive valid beats:
- busy rises once four beats are held.
- The fifth beat is dropped.
- After ready_i=1, exactly the first four beats are output, in order, then valid_o=0 and busy=0.
REQ-037 data_i=8'hFA in mode 0, key=5 -> data_o=8'hFA, last_o=1.
REQ-038 rst_n pulsed low with three beats buffered -> valid_o=0 and busy=0 immediately. No old beat appears after release.

Source files
------------

// File: rtl/cipher_shift_decryptor.sv
// Shift-cipher decryptor: one staging register feeding a show-ahead output FIFO.
// Supports modular byte shift or alphabetic (Caesar) shift; END_TOKEN passes through.
module cipher_shift_decryptor #(
  parameter int                 D_WIDTH    = 8,
  parameter int                 KEY_WIDTH  = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [D_WIDTH-1:0] END_TOKEN  = D_WIDTH'(8'hFA)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 mode_i,
  input  logic                 ready_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 last_o,
  output logic                 busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int KW = (KEY_WIDTH > D_WIDTH) ? KEY_WIDTH : D_WIDTH;
  localparam logic [D_WIDTH-1:0] UC_A = D_WIDTH'(8'h41);
  localparam logic [D_WIDTH-1:0] UC_Z = D_WIDTH'(8'h5A);
  localparam logic [D_WIDTH-1:0] LC_A = D_WIDTH'(8'h61);
  localparam logic [D_WIDTH-1:0] LC_Z = D_WIDTH'(8'h7A);

  logic [D_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic               stage_v, stage_last;
  logic [D_WIDTH-1:0] stage_d;

  logic               accept, push, pop, full;
  logic [D_WIDTH-1:0] dec_d;
  logic [KW-1:0]      key_ext, key_mod;
  logic [4:0]         k5;
  logic [D_WIDTH-1:0] base, off_full;
  logic [5:0]         off, rot;
  logic               is_upper, is_lower;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i;
  // busy looks only at registered occupancy, so there is no input-to-busy path
  assign busy    = ({1'b0, count} + (CW + 1)'(stage_v)) >= (CW + 1)'(FIFO_DEPTH);
  assign accept  = valid_i && !busy;
  assign push    = stage_v && (!full || pop);

  assign data_o = valid_o ? mem[rd_ptr][D_WIDTH-1:0] : '0;
  assign last_o = valid_o ? mem[rd_ptr][D_WIDTH]     : 1'b0;

  assign key_ext = KW'(key);
  assign key_mod = key_ext % KW'(26);
  assign k5      = key_mod[4:0];

  always_comb begin
    dec_d    = data_i;
    is_upper = (data_i >= UC_A) && (data_i <= UC_Z);
    is_lower = (data_i >= LC_A) && (data_i <= LC_Z);
    base     = is_upper ? UC_A : LC_A;
    off_full = data_i - base;
    off      = off_full[5:0];
    // off + 26 - k stays positive, so one conditional subtract gives mod 26
    rot      = off + 6'd26 - {1'b0, k5};
    if (rot >= 6'd26) rot = rot - 6'd26;
    if (data_i == END_TOKEN) begin
      dec_d = data_i;
    end else if (!mode_i) begin
      dec_d = data_i - key_ext[D_WIDTH-1:0];
    end else if (is_upper || is_lower) begin
      dec_d = base + D_WIDTH'(rot);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v    <= 1'b0;
      stage_d    <= '0;
      stage_last <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (accept) begin
        stage_v    <= 1'b1;
        stage_d    <= dec_d;
        stage_last <= (data_i == END_TOKEN);
      end else if (push) begin
        stage_v <= 1'b0;
      end
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {stage_last, stage_d};
  end

endmodule

// File: tb/tb_cipher_shift_decryptor.sv
// Self-checking bench: per-scenario tasks plus a scoreboard queue compared
// against every popped output beat.
module tb_cipher_shift_decryptor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic [15:0] key = '0;
  logic        mode_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o, last_o, busy;

  int tests_run = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  cipher_shift_decryptor #(.D_WIDTH(8), .KEY_WIDTH(16), .FIFO_DEPTH(4), .END_TOKEN(8'hFA)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .key(key),
    .mode_i(mode_i), .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o),
    .last_o(last_o), .busy(busy)
  );

  function automatic logic [8:0] model(input logic [7:0] c, input logic [15:0] k, input logic m);
    int kk, v;
    if (c == 8'hFA) return {1'b1, c};
    if (!m) return {1'b0, 8'(c - k[7:0])};
    kk = int'(k) % 26;
    if (c >= 8'h41 && c <= 8'h5A) begin
      v = ((int'(c) - 65 - kk) % 26 + 26) % 26;
      return {1'b0, 8'(65 + v)};
    end
    if (c >= 8'h61 && c <= 8'h7A) begin
      v = ((int'(c) - 97 - kk) % 26 + 26) % 26;
      return {1'b0, 8'(97 + v)};
    end
    return {1'b0, c};
  endfunction

  // Scoreboard: a pop happens at the next rising edge whenever valid_o && ready_i here.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && valid_o && ready_i) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got data=%h last=%b, required no output", data_o, last_o);
      end else begin
        e = exp_q.pop_front();
        if ({last_o, data_o} !== e) begin
          fails++;
          $display("FAIL scoreboard: got last=%b data=%h, required last=%b data=%h",
                   last_o, data_o, e[8], e[7:0]);
        end
      end
    end
  end

  // Drives one beat for one edge; caller states whether it should be accepted.
  task automatic send(input logic [7:0] d, input logic [15:0] k, input logic m, input bit expect_accept);
    data_i = d; key = k; mode_i = m; valid_i = 1'b1;
    if (expect_accept) exp_q.push_back(model(d, k, m));
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run += 4;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (last_o !== 1'b0)  begin fails++; $display("FAIL reset_last: got %b, required 0", last_o); end
    if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", data_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode0();
    ready_i = 1'b1;
    send(8'h44, 16'h0003, 1'b0, 1'b1);
    tests_run++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL latency_early: valid_o got %b, required 0", valid_o); end
    @(posedge clk); #1;
    tests_run += 2;
    if (valid_o !== 1'b1) begin fails++; $display("FAIL latency_valid: got %b, required 1", valid_o); end
    if (data_o !== 8'h41) begin fails++; $display("FAIL mode0_data: got %h, required 41", data_o); end
    wait_drain("mode0");
    send(8'h01, 16'h0002, 1'b0, 1'b1);
    wait_drain("mode0_wrap");
  endtask

  task automatic test_mode1();
    ready_i = 1'b1;
    send(8'h61, 16'd29, 1'b1, 1'b1);
    send(8'h43, 16'd29, 1'b1, 1'b1);
    send(8'h37, 16'd29, 1'b1, 1'b1);
    wait_drain("mode1");
  endtask

  task automatic test_end_token();
    ready_i = 1'b1;
    send(8'hFA, 16'd5, 1'b0, 1'b1);
    @(posedge clk); #1;
    tests_run += 2;
    if (data_o !== 8'hFA) begin fails++; $display("FAIL end_token_data: got %h, required fa", data_o); end
    if (last_o !== 1'b1)  begin fails++; $display("FAIL end_token_last: got %b, required 1", last_o); end
    send(8'hFA, 16'd7, 1'b1, 1'b1);
    wait_drain("end_token");
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    for (int i = 0; i < 24; i++)
      send(8'($urandom_range(0, 255)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 8; i++)
      send(8'($urandom_range(8'h41, 8'h5A)), 16'($urandom), 1'b1, 1'b1);
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    send(8'h10, 16'h0001, 1'b0, 1'b1);
    send(8'h20, 16'h0001, 1'b0, 1'b1);
    send(8'h30, 16'h0001, 1'b0, 1'b1);
    tests_run++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_three_held: got %b, required 0", busy); end
    send(8'h40, 16'h0001, 1'b0, 1'b1);
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_four_held: got %b, required 1", busy); end
    send(8'h50, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    tests_run += 3;
    if (busy !== 1'b1)    begin fails++; $display("FAIL busy_after_drop: got %b, required 1", busy); end
    if (valid_o !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b, required 1", valid_o); end
    if (data_o !== 8'h0F) begin fails++; $display("FAIL stall_data: got %h, required 0f", data_o); end
    ready_i = 1'b1;
    wait_drain("backpressure");
    tests_run += 2;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL drained_valid: got %b, required 0", valid_o); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL drained_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_midop();
    ready_i = 1'b0;
    send(8'hA1, 16'h0001, 1'b0, 1'b0);
    send(8'hA2, 16'h0001, 1'b0, 1'b0);
    send(8'hA3, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b, required 0", valid_o); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    if (data_o !== 8'h00) begin fails++; $display("FAIL midreset_data: got %h, required 00", data_o); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    data_i = 8'h50; key = 16'h0010; mode_i = 1'b0; valid_i = 1'b1;
    exp_q.push_back(9'h040);
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_end_token();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
